// File: rtl/vga_pixel_painter.sv
// vga_pixel_painter: 2-stage checkerboard + sprite pixel stage; sprite bounce motion enabled by `VGA_PAINTER_BOUNCE_EN
module vga_pixel_painter #(
  parameter int H_ACTIVE = 600,
  parameter int V_ACTIVE = 300,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 24,
  parameter int STEP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_ena_i,
  input  logic [9:0] col_i,
  input  logic [8:0] row_i,
  input  logic       pause_i,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic       pix_valid_o,
  output logic       frame_tick_o,
  output logic [7:0] bounce_cnt_o
);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] ST    = 11'(STEP);
  logic [10:0] x_pos, y_pos, col_w, row_w;
  logic        v1, in_spr, chk, frame_tick;
  assign col_w = {1'b0, col_i};
  assign row_w = {2'b0, row_i};
  assign frame_tick = disp_ena_i && col_i == 10'(H_ACTIVE - 1) && row_i == 9'(V_ACTIVE - 1);
`ifdef VGA_PAINTER_BOUNCE_EN
  typedef enum logic {POS, NEG} dir_e;
  dir_e        dir_x, dir_y, dir_x_nx, dir_y_nx;
  logic [10:0] x_nx, y_nx;
  logic        bx, by;
  logic [7:0]  bounce_cnt;
  // Position moves on the same edge that registers the tick, so the last pixel still uses the old position
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_pos      <= '0;
      y_pos      <= '0;
      dir_x      <= POS;
      dir_y      <= POS;
      bounce_cnt <= '0;
    end else if (frame_tick && !pause_i) begin
      x_pos      <= x_nx;
      y_pos      <= y_nx;
      dir_x      <= dir_x_nx;
      dir_y      <= dir_y_nx;
      bounce_cnt <= bounce_cnt + 8'(bx) + 8'(by);
    end
  always_comb begin
    bx       = dir_x == POS ? x_pos + ST >= X_MAX : x_pos <= ST;
    by       = dir_y == POS ? y_pos + ST >= Y_MAX : y_pos <= ST;
    x_nx     = dir_x == POS ? (bx ? X_MAX : x_pos + ST) : (bx ? '0 : x_pos - ST);
    y_nx     = dir_y == POS ? (by ? Y_MAX : y_pos + ST) : (by ? '0 : y_pos - ST);
    dir_x_nx = bx ? (dir_x == POS ? NEG : POS) : dir_x;
    dir_y_nx = by ? (dir_y == POS ? NEG : POS) : dir_y;
  end
  assign bounce_cnt_o = bounce_cnt;
`else
  logic unused_pause;
  assign unused_pause = pause_i;
  assign x_pos = X_MAX / 11'd2;
  assign y_pos = Y_MAX / 11'd2;
  assign bounce_cnt_o = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1           <= 1'b0;
      in_spr       <= 1'b0;
      chk          <= 1'b0;
      frame_tick_o <= 1'b0;
      red_o        <= '0;
      green_o      <= '0;
      blue_o       <= '0;
      pix_valid_o  <= 1'b0;
    end else begin
      v1           <= disp_ena_i;
      in_spr       <= col_w >= x_pos && col_w < x_pos + 11'(SPRITE_W) &&
                      row_w >= y_pos && row_w < y_pos + 11'(SPRITE_H);
      chk          <= col_i[4] ^ row_i[4];
      frame_tick_o <= frame_tick;
      red_o        <= !v1 ? 4'h0 : in_spr ? 4'hF : chk ? 4'h4 : 4'h0;
      green_o      <= !v1 ? 4'h0 : in_spr ? 4'hF : chk ? 4'h4 : 4'h0;
      blue_o       <= !v1 ? 4'h0 : in_spr ? 4'h0 : chk ? 4'h4 : 4'h8;
      pix_valid_o  <= v1;
    end
endmodule
